// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART widths and TX scheduler state type
package uart_pkg;

   localparam int MAX_UART_DATA_W = 8;
   localparam int TOTAL_CONF_W    = 5;
   localparam int BAUD_RATE_SEL_W = 2;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      START     = 2'd1,
      WAIT_DONE = 2'd2
   } tx_sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick with optional lock to one owner
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = 2
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDX_W-1:0]   ptr_i,
   input  logic               lock_i,
   input  logic [IDX_W-1:0]   lock_idx_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [IDX_W-1:0]   idx_o,
   output logic               found_o
);

   logic [IDX_W-1:0] cand;

   always_comb begin
      gnt_o   = '0;
      idx_o   = '0;
      found_o = 1'b0;
      cand    = '0;
      if (lock_i) begin
         if (req_i[lock_idx_i]) begin
            gnt_o[lock_idx_i] = 1'b1;
            idx_o             = lock_idx_i;
            found_o           = 1'b1;
         end
      end else begin
         // Walk upward from the pointer with wrap; the first hit wins.
         for (int i = 0; i < NUM_REQ; i++) begin
            cand = IDX_W'((int'(ptr_i) + i) % NUM_REQ);
            if (!found_o && req_i[cand]) begin
               gnt_o[cand] = 1'b1;
               idx_o       = cand;
               found_o     = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - shares the UART TX path between requesters with packet lock and watchdog
module uart_tx_scheduler #(
   parameter int NUM_REQ         = 4,
   parameter int REQ_IDX_W       = 2,
   parameter int MAX_UART_DATA_W = uart_pkg::MAX_UART_DATA_W,
   parameter int TOTAL_CONF_W    = uart_pkg::TOTAL_CONF_W,
   parameter int BAUD_RATE_SEL_W = uart_pkg::BAUD_RATE_SEL_W,
   parameter int TIMEOUT_W       = 20,
   parameter int TIMEOUT_CYCLES  = 1000000
) (
   input  logic                               clk_i,
   input  logic                               rst_ni,
   input  logic                               enable_i,
   input  logic [NUM_REQ-1:0]                 req_valid_i,
   input  logic [NUM_REQ-1:0]                 req_last_i,
   input  logic [NUM_REQ*MAX_UART_DATA_W-1:0] req_data_i,
   output logic [NUM_REQ-1:0]                 req_ready_o,
   input  logic [TOTAL_CONF_W-1:0]            cfg_conf_i,
   input  logic [BAUD_RATE_SEL_W-1:0]         cfg_baud_i,
   output logic                               tx_en_o,
   output logic                               tx_start_o,
   output logic [MAX_UART_DATA_W-1:0]         tx_data_o,
   output logic [TOTAL_CONF_W-1:0]            tx_conf_o,
   output logic [BAUD_RATE_SEL_W-1:0]         baud_sel_o,
   input  logic                               tx_done_i,
   input  logic                               tx_busy_i,
   output logic [REQ_IDX_W-1:0]               grant_idx_o,
   output logic                               locked_o,
   output logic                               timeout_err_o,
   input  logic                               err_clr_i
);
   import uart_pkg::*;

   tx_sched_state_e            state_q;
   logic [REQ_IDX_W-1:0]       rr_ptr_q;
   logic [REQ_IDX_W-1:0]       grant_q;
   logic                       locked_q;
   logic [MAX_UART_DATA_W-1:0] data_q;
   logic                       start_q;
   logic                       en_q;
   logic [TOTAL_CONF_W-1:0]    conf_q;
   logic [BAUD_RATE_SEL_W-1:0] baud_q;
   logic [TIMEOUT_W-1:0]       wd_q;
   logic [TIMEOUT_W-1:0]       wd_d;
   logic                       err_q;

   logic [NUM_REQ-1:0]         arb_gnt;
   logic [REQ_IDX_W-1:0]       arb_idx;
   logic                       arb_found;
   logic                       accept;
   logic                       timeout_hit;
   logic [REQ_IDX_W-1:0]       next_ptr;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (REQ_IDX_W)
   ) u_arb (
      .req_i      (req_valid_i),
      .ptr_i      (rr_ptr_q),
      .lock_i     (locked_q),
      .lock_idx_i (grant_q),
      .gnt_o      (arb_gnt),
      .idx_o      (arb_idx),
      .found_o    (arb_found)
   );

   assign accept      = (state_q == IDLE) && enable_i && !tx_busy_i && arb_found;
   assign req_ready_o = accept ? arb_gnt : '0;
   assign wd_d        = wd_q + 1'b1;
   assign timeout_hit = (wd_d == TIMEOUT_W'(TIMEOUT_CYCLES - 1));
   assign next_ptr    = (grant_q == REQ_IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         rr_ptr_q <= '0;
         grant_q  <= '0;
         locked_q <= 1'b0;
         data_q   <= '0;
         start_q  <= 1'b0;
         en_q     <= 1'b0;
         conf_q   <= '0;
         baud_q   <= '0;
         wd_q     <= '0;
         err_q    <= 1'b0;
      end else begin
         en_q    <= enable_i;
         start_q <= 1'b0;
         // Config only follows the inputs while no frame or packet is in progress.
         if (state_q == IDLE && !tx_busy_i && !locked_q) begin
            conf_q <= cfg_conf_i;
            baud_q <= cfg_baud_i;
         end
         if (err_clr_i) begin
            err_q <= 1'b0;
         end
         case (state_q)
            IDLE: begin
               if (accept) begin
                  data_q   <= req_data_i[int'(arb_idx)*MAX_UART_DATA_W +: MAX_UART_DATA_W];
                  grant_q  <= arb_idx;
                  locked_q <= ~req_last_i[arb_idx];
                  start_q  <= 1'b1;
                  state_q  <= START;
               end
            end
            START: begin
               wd_q    <= '0;
               state_q <= WAIT_DONE;
            end
            WAIT_DONE: begin
               wd_q <= wd_d;
               if (tx_done_i) begin
                  if (!locked_q) begin
                     rr_ptr_q <= next_ptr;
                  end
                  state_q <= IDLE;
               end else if (timeout_hit) begin
                  err_q    <= 1'b1;
                  locked_q <= 1'b0;
                  rr_ptr_q <= next_ptr;
                  state_q  <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign tx_en_o       = en_q;
   assign tx_start_o    = start_q;
   assign tx_data_o     = data_q;
   assign tx_conf_o     = conf_q;
   assign baud_sel_o    = baud_q;
   assign grant_idx_o   = grant_q;
   assign locked_o      = locked_q;
   assign timeout_err_o = err_q;

endmodule
